// File: rtl/fetch_sequencer.sv
// Dual-issue fetch sequencer: owns the fetch PC, issues 8-byte pair reads, tracks fetch2 pair state and flush.
// Optional FETCH_PERF_EN adds saturating pair/stall/redirect counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        pred_taken_i,
    input  logic        pred_slot_i,
    input  logic [31:0] pred_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic        f2_valid_o,
    output logic [31:0] f2_pc_o,
    output logic        kill_0_o,
    output logic        zero_1_o,
    output logic        pred_1_o,
    output logic        flush_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_pairs_o,
    output logic [31:0] perf_stalls_o,
    output logic [31:0] perf_redirects_o
`endif
);

    localparam int unsigned AW         = 32;
    localparam int unsigned PAIR_BYTES = 8;
    localparam logic [AW-1:0] PC_RST   = {RESET_PC[AW-1:3], 3'b000};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            cur_kill0_q, cur_kill0_d;
    logic            imem_req_q, imem_req_d;
    logic            f2_valid_q, f2_valid_d;
    logic [AW-1:0]   f2_pc_q, f2_pc_d;
    logic            kill_0_q, kill_0_d;
    logic            zero_1_q, zero_1_d;
    logic            pred_1_q, pred_1_d;
    logic            active;
    logic            pred_eff;
    logic            unused_low_bits;

    assign active   = (state_q != ST_IDLE);
    // A slot0 prediction is void when the pair is entered at its odd word.
    assign pred_eff = pred_taken_i && !(!pred_slot_i && cur_kill0_q);
    assign unused_low_bits = ^{redirect_pc_i[1:0], pred_target_i[1:0]};

    // Next-state, next-PC and fetch2 pair control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cur_kill0_d = cur_kill0_q;
        imem_req_d  = imem_req_q;
        f2_valid_d  = f2_valid_q;
        f2_pc_d     = f2_pc_q;
        kill_0_d    = kill_0_q;
        zero_1_d    = zero_1_q;
        pred_1_d    = pred_1_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d    = ST_RUN;
                imem_req_d = 1'b1;
            end
            ST_RUN:   state_d = redirect_i ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = redirect_i ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (active) begin
            if (redirect_i) begin
                pc_d        = {redirect_pc_i[AW-1:3], 3'b000};
                cur_kill0_d = redirect_pc_i[2];
                f2_valid_d  = 1'b0;
                f2_pc_d     = pc_q;
                kill_0_d    = cur_kill0_q;
                zero_1_d    = 1'b0;
                pred_1_d    = 1'b0;
            end else if (!stall_i) begin
                f2_valid_d = imem_req_q;
                f2_pc_d    = pc_q;
                kill_0_d   = cur_kill0_q;
                zero_1_d   = pred_eff && !pred_slot_i;
                pred_1_d   = pred_eff && pred_slot_i;
                if (pred_eff) begin
                    pc_d        = {pred_target_i[AW-1:3], 3'b000};
                    cur_kill0_d = pred_target_i[2];
                end else begin
                    pc_d        = pc_q + AW'(PAIR_BYTES);
                    cur_kill0_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_RST;
            cur_kill0_q <= 1'b0;
            imem_req_q  <= 1'b0;
            f2_valid_q  <= 1'b0;
            f2_pc_q     <= '0;
            kill_0_q    <= 1'b0;
            zero_1_q    <= 1'b0;
            pred_1_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cur_kill0_q <= cur_kill0_d;
            imem_req_q  <= imem_req_d;
            f2_valid_q  <= f2_valid_d;
            f2_pc_q     <= f2_pc_d;
            kill_0_q    <= kill_0_d;
            zero_1_q    <= zero_1_d;
            pred_1_q    <= pred_1_d;
        end
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = pc_q;
    assign f2_valid_o  = f2_valid_q;
    assign f2_pc_o     = f2_pc_q;
    assign kill_0_o    = kill_0_q;
    assign zero_1_o    = zero_1_q;
    assign pred_1_o    = pred_1_q;
    // First flush cycle follows the redirect pulse; the second comes from the FLUSH state.
    assign flush_o     = (active && redirect_i) || (state_q == ST_FLUSH);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_pairs_q, perf_pairs_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        perf_pairs_d     = sat_inc(perf_pairs_q, f2_valid_q && !stall_i);
        perf_stalls_d    = sat_inc(perf_stalls_q, (state_q == ST_RUN) && stall_i);
        perf_redirects_d = sat_inc(perf_redirects_q, active && redirect_i);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            perf_pairs_q     <= '0;
            perf_stalls_q    <= '0;
            perf_redirects_q <= '0;
        end else begin
            perf_pairs_q     <= perf_pairs_d;
            perf_stalls_q    <= perf_stalls_d;
            perf_redirects_q <= perf_redirects_d;
        end
    end

    assign perf_pairs_o     = perf_pairs_q;
    assign perf_stalls_o    = perf_stalls_q;
    assign perf_redirects_o = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vector table, async reset check, random run against a pair-level model.
module tb_fetch_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        pred_slot_i = 1'b0;
    logic [31:0] pred_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        f2_valid_o;
    logic [31:0] f2_pc_o;
    logic        kill_0_o;
    logic        zero_1_o;
    logic        pred_1_o;
    logic        flush_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_pairs_o;
    logic [31:0] perf_stalls_o;
    logic [31:0] perf_redirects_o;
`endif

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clock_i       (clock_i),
        .reset_ni      (reset_ni),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pred_taken_i  (pred_taken_i),
        .pred_slot_i   (pred_slot_i),
        .pred_target_i (pred_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .f2_valid_o    (f2_valid_o),
        .f2_pc_o       (f2_pc_o),
        .kill_0_o      (kill_0_o),
        .zero_1_o      (zero_1_o),
        .pred_1_o      (pred_1_o),
        .flush_o       (flush_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_pairs_o     (perf_pairs_o),
        .perf_stalls_o    (perf_stalls_o),
        .perf_redirects_o (perf_redirects_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pair-level reference model: where fetch is, what fetch2 holds, whether a second flush is owed.
    bit          m_run;
    bit          m_flush2;
    logic [31:0] m_pc;
    bit          m_entry_odd;
    bit          m_f2_valid;
    logic [31:0] m_f2_pc;
    bit          m_f2_k0, m_f2_z1, m_f2_p1;
    longint      m_pairs, m_stalls, m_redirs;

    task automatic m_reset();
        m_run = 0; m_flush2 = 0; m_pc = 32'h0; m_entry_odd = 0;
        m_f2_valid = 0; m_f2_pc = 32'h0; m_f2_k0 = 0; m_f2_z1 = 0; m_f2_p1 = 0;
        m_pairs = 0; m_stalls = 0; m_redirs = 0;
    endtask

    task automatic m_step();
        bit taken;
        if (!m_run) begin
            m_run = 1;
            return;
        end
        if (m_f2_valid && !stall_i) m_pairs++;
        if (stall_i && !m_flush2) m_stalls++;
        if (redirect_i) m_redirs++;
        taken = pred_taken_i && !(pred_slot_i == 1'b0 && m_entry_odd);
        if (redirect_i) begin
            m_f2_valid  = 0;
            m_pc        = redirect_pc_i & ~32'h7;
            m_entry_odd = redirect_pc_i[2];
            m_flush2    = 1;
        end else begin
            m_flush2 = 0;
            if (!stall_i) begin
                m_f2_valid = 1;
                m_f2_pc    = m_pc;
                m_f2_k0    = m_entry_odd;
                m_f2_z1    = taken && !pred_slot_i;
                m_f2_p1    = taken && pred_slot_i;
                if (taken) begin
                    m_pc        = pred_target_i & ~32'h7;
                    m_entry_odd = pred_target_i[2];
                end else begin
                    m_pc        = m_pc + 32'd8;
                    m_entry_odd = 0;
                end
            end
        end
    endtask

    task automatic m_check(input string tag);
        chk({tag, "_req"}, imem_req_o, 32'(m_run));
        chk({tag, "_addr"}, imem_addr_o, m_pc);
        chk({tag, "_valid"}, f2_valid_o, 32'(m_f2_valid));
        chk({tag, "_flush"}, flush_o, 32'((m_run && redirect_i) || m_flush2));
        if (m_f2_valid) begin
            chk({tag, "_f2pc"}, f2_pc_o, m_f2_pc);
            chk({tag, "_kill0"}, kill_0_o, 32'(m_f2_k0));
            chk({tag, "_zero1"}, zero_1_o, 32'(m_f2_z1));
            chk({tag, "_pred1"}, pred_1_o, 32'(m_f2_p1));
        end
    endtask

    // Apply inputs just after an edge, check before the next, then advance the model.
    task automatic do_cycle(input logic s, input logic r, input logic [31:0] rp,
                            input logic t, input logic sl, input logic [31:0] tg, input string tag);
        stall_i = s; redirect_i = r; redirect_pc_i = rp;
        pred_taken_i = t; pred_slot_i = sl; pred_target_i = tg;
        #1;
        m_check(tag);
        @(posedge clock_i);
        m_step();
        #1;
    endtask

    typedef struct {
        logic        s, r;
        logic [31:0] rp;
        logic        t, sl;
        logic [31:0] tg;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_f2pc;
        logic        e_k0, e_z1, e_p1, e_fl;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic t, input logic sl, input logic [31:0] tg,
                                input logic e_req, input logic [31:0] e_addr, input logic e_v,
                                input logic [31:0] e_f2pc, input logic e_k0, input logic e_z1,
                                input logic e_p1, input logic e_fl);
        vec_t v;
        v.s = s; v.r = r; v.rp = rp; v.t = t; v.sl = sl; v.tg = tg;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_f2pc = e_f2pc;
        v.e_k0 = e_k0; v.e_z1 = e_z1; v.e_p1 = e_p1; v.e_fl = e_fl;
        return v;
    endfunction

    vec_t vt[21];

    initial begin
        //          s  r  rpc           t  sl tgt       req addr          v  f2pc          k0 z1 p1 fl
        vt[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,         0, 32'h0,        0, 0, 0, 0);
        vt[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h0,         0, 32'h0,        0, 0, 0, 0);
        vt[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h8,         1, 32'h0,        0, 0, 0, 0);
        vt[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h10,        1, 32'h8,        0, 0, 0, 0);
        vt[4]  = mk(0, 1, 32'h104,      0, 0, 32'h0,    1, 32'h18,        1, 32'h10,       0, 0, 0, 1);
        vt[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h100,       0, 32'h0,        0, 0, 0, 1);
        vt[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h108,       1, 32'h100,      1, 0, 0, 0);
        vt[7]  = mk(0, 1, 32'h40,       0, 0, 32'h0,    1, 32'h110,       1, 32'h108,      0, 0, 0, 1);
        vt[8]  = mk(0, 0, 32'h0,        1, 0, 32'h200,  1, 32'h40,        0, 32'h0,        0, 0, 0, 1);
        vt[9]  = mk(0, 0, 32'h0,        1, 1, 32'h300,  1, 32'h200,       1, 32'h40,       0, 1, 0, 0);
        vt[10] = mk(0, 1, 32'h404,      0, 0, 32'h0,    1, 32'h300,       1, 32'h200,      0, 0, 1, 1);
        vt[11] = mk(0, 0, 32'h0,        1, 0, 32'h800,  1, 32'h400,       0, 32'h0,        0, 0, 0, 1);
        vt[12] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h408,       1, 32'h400,      1, 0, 0, 0);
        vt[13] = mk(1, 0, 32'h0,        0, 0, 32'h0,    1, 32'h410,       1, 32'h408,      0, 0, 0, 0);
        vt[14] = mk(1, 1, 32'h500,      0, 0, 32'h0,    1, 32'h410,       1, 32'h408,      0, 0, 0, 1);
        vt[15] = mk(1, 0, 32'h0,        0, 0, 32'h0,    1, 32'h500,       0, 32'h0,        0, 0, 0, 1);
        vt[16] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h500,       0, 32'h0,        0, 0, 0, 0);
        vt[17] = mk(0, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,   1, 32'h508,       1, 32'h500,      0, 0, 0, 1);
        vt[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'hFFFF_FFF8, 0, 32'h0,        0, 0, 0, 1);
        vt[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h0,         1, 32'hFFFF_FFF8, 0, 0, 0, 0);
        vt[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,    1, 32'h8,         1, 32'h0,        0, 0, 0, 0);

        repeat (2) @(posedge clock_i);
        #1 reset_ni = 1'b1;

        // Directed table from reset release
        for (int i = 0; i < 21; i++) begin
            stall_i = vt[i].s; redirect_i = vt[i].r; redirect_pc_i = vt[i].rp;
            pred_taken_i = vt[i].t; pred_slot_i = vt[i].sl; pred_target_i = vt[i].tg;
            #1;
            chk($sformatf("v%0d_req", i), imem_req_o, 32'(vt[i].e_req));
            chk($sformatf("v%0d_addr", i), imem_addr_o, vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), f2_valid_o, 32'(vt[i].e_v));
            chk($sformatf("v%0d_flush", i), flush_o, 32'(vt[i].e_fl));
            if (vt[i].e_v) begin
                chk($sformatf("v%0d_f2pc", i), f2_pc_o, vt[i].e_f2pc);
                chk($sformatf("v%0d_kill0", i), kill_0_o, 32'(vt[i].e_k0));
                chk($sformatf("v%0d_zero1", i), zero_1_o, 32'(vt[i].e_z1));
                chk($sformatf("v%0d_pred1", i), pred_1_o, 32'(vt[i].e_p1));
            end
            @(posedge clock_i);
            #1;
        end

        // Asynchronous reset mid-run: outputs drop without a clock edge
        stall_i = 0; redirect_i = 0; pred_taken_i = 0;
        #1 reset_ni = 1'b0;
        #1;
        chk("arst_req", imem_req_o, 32'h0);
        chk("arst_addr", imem_addr_o, 32'h0);
        chk("arst_valid", f2_valid_o, 32'h0);
        chk("arst_f2pc", f2_pc_o, 32'h0);
        chk("arst_kill0", kill_0_o, 32'h0);
        chk("arst_zero1", zero_1_o, 32'h0);
        chk("arst_pred1", pred_1_o, 32'h0);
        chk("arst_flush", flush_o, 32'h0);
        @(posedge clock_i);
        #1 reset_ni = 1'b1;
        m_reset();

        // Random run against the model
        for (int c = 0; c < 3000; c++) begin
            logic        s, r, t, sl;
            logic [31:0] rp, tg;
            s  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 3) == 0);
            sl = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            tg = $urandom;
            do_cycle(s, r, rp, t, sl, tg, "rnd");
        end
`ifdef FETCH_PERF_EN
        chk("rnd_perf_pairs", perf_pairs_o, 32'(m_pairs));
        chk("rnd_perf_stalls", perf_stalls_o, 32'(m_stalls));
        chk("rnd_perf_redirects", perf_redirects_o, 32'(m_redirs));

        // 1 redirect, 10 live pairs, 3 stalls
        reset_ni = 1'b0;
        #1;
        chk("perf_rst_pairs", perf_pairs_o, 32'h0);
        @(posedge clock_i);
        #1 reset_ni = 1'b1;
        m_reset();
        do_cycle(0, 0, 32'h0, 0, 0, 32'h0, "pf_idle");
        do_cycle(0, 1, 32'h100, 0, 0, 32'h0, "pf_redir");
        do_cycle(0, 0, 32'h0, 0, 0, 32'h0, "pf_flush");
        for (int k = 0; k < 10; k++) do_cycle(0, 0, 32'h0, 0, 0, 32'h0, "pf_run");
        for (int k = 0; k < 3; k++) do_cycle(1, 0, 32'h0, 0, 0, 32'h0, "pf_stall");
        stall_i = 0;
        #1;
        chk("perf_pairs", perf_pairs_o, 32'd10);
        chk("perf_stalls", perf_stalls_o, 32'd3);
        chk("perf_redirects", perf_redirects_o, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
